// File: rtl/key_filter_if.sv
// rtl/key_filter_if.sv - key filter signal bundle: raw keys in, press code and debounced levels out
interface key_filter_if;
  logic [3:0] key_in;
  logic [2:0] key_val;
  logic [3:0] key_state;

  modport master (output key_in, input key_val, input key_state);
  modport slave  (input key_in, output key_val, output key_state);
endinterface

// File: rtl/key_filter.sv
// rtl/key_filter.sv - 4-key debouncer: per-key synchronizer and FSM, pending-press queue drained lowest index first
module key_filter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  key_filter_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_st_e;

  key_st_e          state_q [4];
  key_st_e          state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       pend_q;
  logic [3:0]       pend_d;
  logic [3:0]       press_set;
  logic [3:0]       served;
  logic [3:0]       held_d;
  logic [2:0]       code_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_TGT) ? c : c + CNT_W'(1);
  endfunction

  // Released keys read high, so the synchronizer resets to 1 to avoid a phantom press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 4'hf;
      sync2_q <= 4'hf;
    end else begin
      sync1_q <= bus.key_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    press_set = '0;
    held_d    = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            cnt_d[i] = sat_inc(cnt_q[i]);
            if (cnt_d[i] == CNT_TGT) begin
              state_d[i]   = HELD;
              press_set[i] = 1'b1;
            end
          end else begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        end
        HELD: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q[i]) begin
            cnt_d[i] = sat_inc(cnt_q[i]);
            if (cnt_d[i] == CNT_TGT) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end
          end else begin
            state_d[i] = HELD;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_WAIT);
    end
  end

  // A press accepted in the same cycle its earlier entry drains is a new press and re-queues.
  always_comb begin
    served = '0;
    code_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (pend_q[i] && (served == 4'b0000)) begin
        served[i] = 1'b1;
        code_d    = 3'(i + 1);
      end
    end
    pend_d = (pend_q & ~served) | press_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pend_q        <= '0;
      bus.key_val   <= '0;
      bus.key_state <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pend_q        <= pend_d;
      bus.key_val   <= code_d;
      bus.key_state <= held_d;
    end
  end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz), legal range 2..2^24; it sets the consecutive stable samples needed to accept a key edge.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all logic rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port key_in, input, 4 bits: raw mechanical keys, active-low, asynchronous to clk, bouncing.
REQ-005 The block SHALL have port key_val, output, 3 bits: one-cycle press code; 3'b000 = none, 3'b001..3'b100 = key_in[0]..key_in[3] press accepted; 3'b101..3'b111 never driven.
REQ-006 The block SHALL have port key_state, output, 4 bits: debounced level per key, 1 = held.

Function
REQ-007 Each key_in bit SHALL pass through a 2-flop synchronizer; the synchronizer output is the only sample used downstream.
REQ-008 Each key SHALL run an independent 4-state FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-009 IDLE -> PRESS_WAIT on a low sample, with the key's counter cleared to 1; otherwise stay.
REQ-010 PRESS_WAIT: a low sample increments the counter; on reaching DEBOUNCE_CYCLES, go to HELD and set the key's pending-press bit; a high sample returns to IDLE with the counter cleared.
REQ-011 HELD -> RELEASE_WAIT on a high sample, with the counter cleared to 1.
REQ-012 RELEASE_WAIT: a high sample increments the counter; on reaching DEBOUNCE_CYCLES, go to IDLE; a low sample returns to HELD without setting pending.
REQ-013 key_state[i] SHALL be 1 exactly while key i's FSM is in HELD or RELEASE_WAIT.
REQ-014 Counters SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits wide, saturate, and never wrap.
REQ-015 Press latency: key_val SHALL carry the code in the cycle after the DEBOUNCE_CYCLES-th consecutive low synchronizer sample, i.e. DEBOUNCE_CYCLES+3 clocks after key_in first settles low, with no contention.
REQ-016 Each accepted press SHALL produce exactly one key_val cycle; holding a key produces no repeats; release produces no code.
REQ-017 Pending bits SHALL form a 4-entry queue; each cycle the lowest-index pending bit is reported on key_val and cleared, and key_val = 000 when none is pending.
REQ-018 Simultaneous acceptance: presses accepted in the same cycle SHALL be reported on consecutive cycles in ascending index order, none lost.
REQ-019 If a key's pending bit is set while still unreported (re-press before drain), it SHALL stay a single pending entry; the second press is merged, not duplicated.
REQ-020 key_val and key_state SHALL be registered outputs.

Reset
REQ-021 While rst = 0 at a clk edge: all FSMs SHALL go to IDLE, counters to 0, pending bits to 0, synchronizer flops to 1 (released), key_val to 3'b000, key_state to 4'b0000.
REQ-022 Reset mid-debounce or mid-hold SHALL discard the partial count and any queued press; a key still held low after reset is re-debounced from IDLE and yields one press code.

Verification (DEBOUNCE_CYCLES = 16)
REQ-023 Clean press: key_in = 4'b1110 held 40 cycles -> key_val = 3'b001 for exactly one cycle, 19 clocks after the change; key_state = 4'b0001 from that cycle on.
REQ-024 Bounce: key_in[1] toggles every 5 cycles for 60 cycles, then stays low -> no key_val during the toggling; exactly one 3'b010 after 16 stable samples.
REQ-025 Simultaneous: key_in 4'b1111 -> 4'b0000 in one cycle -> key_val = 001, 010, 011, 100 on four consecutive cycles, then 000; key_state = 4'b1111.
REQ-026 Release glitch: key 2 in HELD, high for 10 cycles, low again -> key_state[2] stays 1, no new code; high for 20 cycles -> key_state[2] = 0 after 16 samples.
REQ-027 Reset mid-operation: rst = 0 for 1 cycle at sample 10 of a key 3 press, key held low throughout -> all outputs 0 during reset; one 3'b100 code 19 clocks after rst returns to 1.
